// File: rtl/expr_eval_ctrl.sv
// Streaming checker/evaluator for "digit (op digit)* '='" with '*' binding tighter than '+'.
// Optional input FIFO is enabled by defining EXPR_EVAL_FIFO_EN.
module expr_eval_ctrl #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_err,
  output logic             busy
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OPND = 3'd1;
  localparam logic [2:0] ST_OPER = 3'd2;
  localparam logic [2:0] ST_SKIP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  logic [2:0]       state_r, state_s;
  logic [WIDTH-1:0] sum_r, sum_s;
  logic [WIDTH-1:0] prod_r, prod_s;
  logic             pend_mul_r, pend_mul_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             res_err_r, res_err_s;
  logic             consume_s;
  logic [7:0]       char_s;
  logic             fifo_nonempty_s;
  logic [WIDTH-1:0] digit_s;
  logic [WIDTH-1:0] mul_s;

`ifdef EXPR_EVAL_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s, empty_s, push_s, pop_s;

  assign full_s          = (count_r == FULL_CNT);
  assign empty_s         = (count_r == {(AW+1){1'b0}});
  assign push_s          = in_valid & ~full_s;
  assign pop_s           = (state_r != ST_DONE) & ~empty_s;
  assign in_ready        = ~full_s;
  assign consume_s       = pop_s;
  assign char_s          = mem_r[rd_ptr_r];
  assign fifo_nonempty_s = ~empty_s;

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_char;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
`else
  assign in_ready        = (state_r != ST_DONE);
  assign consume_s       = in_valid & in_ready;
  assign char_s          = in_char;
  assign fifo_nonempty_s = 1'b0;
`endif

  assign digit_s = WIDTH'(char_s[3:0]);
  assign mul_s   = prod_r * digit_s;

  // Next-state and datapath update, one character per consume
  always_comb begin
    state_s    = state_r;
    sum_s      = sum_r;
    prod_s     = prod_r;
    pend_mul_s = pend_mul_r;
    result_s   = result_r;
    res_err_s  = res_err_r;
    if (state_r == ST_DONE) begin
      if (res_ready) begin
        state_s    = ST_IDLE;
        sum_s      = {WIDTH{1'b0}};
        prod_s     = {WIDTH{1'b0}};
        pend_mul_s = 1'b0;
      end else begin
        state_s = ST_DONE;
      end
    end else if (consume_s) begin
      case (state_r)
        ST_IDLE: begin
          if (is_digit(char_s)) begin
            state_s    = ST_OPND;
            prod_s     = digit_s;
            sum_s      = {WIDTH{1'b0}};
            pend_mul_s = 1'b0;
          end else if (char_s == 8'h3D) begin
            state_s   = ST_DONE;
            result_s  = {WIDTH{1'b0}};
            res_err_s = 1'b1;
          end else begin
            state_s = ST_SKIP;
          end
        end
        ST_OPND: begin
          if (char_s == 8'h2B) begin
            state_s    = ST_OPER;
            sum_s      = sum_r + prod_r;
            pend_mul_s = 1'b0;
          end else if (char_s == 8'h2A) begin
            state_s    = ST_OPER;
            pend_mul_s = 1'b1;
          end else if (char_s == 8'h3D) begin
            state_s   = ST_DONE;
            result_s  = sum_r + prod_r;
            res_err_s = 1'b0;
          end else begin
            state_s = ST_SKIP;
          end
        end
        ST_OPER: begin
          if (is_digit(char_s)) begin
            state_s = ST_OPND;
            prod_s  = pend_mul_r ? mul_s : digit_s;
          end else if (char_s == 8'h3D) begin
            state_s   = ST_DONE;
            result_s  = {WIDTH{1'b0}};
            res_err_s = 1'b1;
          end else begin
            state_s = ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (char_s == 8'h3D) begin
            state_s   = ST_DONE;
            result_s  = {WIDTH{1'b0}};
            res_err_s = 1'b1;
          end else begin
            state_s = ST_SKIP;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          sum_s      = {WIDTH{1'b0}};
          prod_s     = {WIDTH{1'b0}};
          pend_mul_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r    <= ST_IDLE;
      sum_r      <= {WIDTH{1'b0}};
      prod_r     <= {WIDTH{1'b0}};
      pend_mul_r <= 1'b0;
      result_r   <= {WIDTH{1'b0}};
      res_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      sum_r      <= sum_s;
      prod_r     <= prod_s;
      pend_mul_r <= pend_mul_s;
      result_r   <= result_s;
      res_err_r  <= res_err_s;
    end
  end

  assign res_valid = (state_r == ST_DONE);
  assign result    = result_r;
  assign res_err   = res_err_r;
  assign busy      = (state_r != ST_IDLE) | fifo_nonempty_s;

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Directed self-checking bench for expr_eval_ctrl; a WIDTH=4 instance shares the stimulus.
module tb_expr_eval_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        res_ready;
  logic [7:0]  in_char;
  logic        in_ready, res_valid, res_err, busy;
  logic [15:0] result;
  logic        in_ready4, res_valid4, res_err4, busy4;
  logic [3:0]  result4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  expr_eval_ctrl #(.WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .res_valid(res_valid), .res_ready(res_ready), .result(result), .res_err(res_err), .busy(busy)
  );

  expr_eval_ctrl #(.WIDTH(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready4), .in_char(in_char),
    .res_valid(res_valid4), .res_ready(res_ready), .result(result4), .res_err(res_err4), .busy(busy4)
  );

  task automatic send_char(input logic [7:0] c);
    int cnt;
    in_char  = c;
    in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int cnt;
    cnt = 0;
    while (!res_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    tests++;
    if (res_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_valid: res_valid=%b required 1", name, res_valid);
    end
  endtask

  task automatic take_result(input string name, input logic [15:0] exp_v, input logic exp_e);
    wait_valid(name);
    tests++;
    if (result !== exp_v || res_err !== exp_e) begin
      fails++;
      $display("FAIL %s_value: result=%0d err=%b required %0d err=%b", name, result, res_err, exp_v, exp_e);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    tests++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_release: res_valid=%b required 0", name, res_valid);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_char = 8'h00;
    repeat (2) @(negedge clk);
    tests++;
    if (res_valid !== 1'b0 || result !== 16'd0 || res_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b result=%0d err=%b busy=%b required 0 0 0 0",
               res_valid, result, res_err, busy);
    end
    clr = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_valid_exprs();
    send_str("1+2*3=");
    take_result("expr_1p2m3", 16'd7, 1'b0);
    send_str("2*3*4+5=");
    take_result("expr_2m3m4p5", 16'd29, 1'b0);
    send_char("7");
    tests++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_expr: busy=%b valid=%b required 1 0", busy, res_valid);
    end
    send_char("=");
    in_valid = 1'b0;
`ifndef EXPR_EVAL_FIFO_EN
    tests++;
    if (res_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency_1: res_valid=%b required 1", res_valid);
    end
`endif
    take_result("expr_7", 16'd7, 1'b0);
  endtask

  task automatic test_errors();
    string errs [7] = '{"1++2=", "+3=", "12=", "a=", "=", "1+=", "1*x5="};
    for (int i = 0; i < 7; i++) begin
      send_str(errs[i]);
      take_result({"err_", errs[i]}, 16'd0, 1'b1);
    end
  endtask

  task automatic test_width();
    send_str("9*9+9=");
    wait_valid("width");
    tests++;
    if (res_valid4 !== 1'b1 || result4 !== 4'd10 || res_err4 !== 1'b0) begin
      fails++;
      $display("FAIL width4: valid=%b result=%0d err=%b required 1 10 0", res_valid4, result4, res_err4);
    end
    take_result("width16", 16'd90, 1'b0);
  endtask

  task automatic test_hold();
    send_str("3*3=");
    wait_valid("hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
`ifndef EXPR_EVAL_FIFO_EN
      if (res_valid !== 1'b1 || result !== 16'd9 || res_err !== 1'b0 || in_ready !== 1'b0) begin
`else
      if (res_valid !== 1'b1 || result !== 16'd9 || res_err !== 1'b0) begin
`endif
        fails++;
        $display("FAIL hold_%0d: valid=%b result=%0d err=%b in_ready=%b required 1 9 0 0",
                 i, res_valid, result, res_err, in_ready);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    tests++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: valid=%b in_ready=%b required 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_clr();
    send_str("1+2");
    #2 clr = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL clr_mid_busy: busy=%b required 0", busy);
    end
    @(negedge clk);
    clr = 1'b0;
    send_str("4=");
    take_result("clr_then_4", 16'd4, 1'b0);
    send_str("5=");
    wait_valid("clr_done");
    #2 clr = 1'b1;
    #1;
    tests++;
    if (res_valid !== 1'b0 || result !== 16'd0) begin
      fails++;
      $display("FAIL clr_in_done: valid=%b result=%0d required 0 0", res_valid, result);
    end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

`ifdef EXPR_EVAL_FIFO_EN
  task automatic test_fifo();
    res_ready = 1'b0;
    send_str("2=5+5=");
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fifo_full: in_ready=%b required 0", in_ready);
    end
    take_result("fifo_first", 16'd2, 1'b0);
    take_result("fifo_second", 16'd10, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_valid_exprs();
    test_errors();
    test_width();
    test_hold();
    test_clr();
`ifdef EXPR_EVAL_FIFO_EN
    test_fifo();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
